// File: rtl/pipelined_adder.sv
// Pipelined N-bit adder/subtractor: one W-bit chunk resolved per stage, carry registered
// between stages, valid/ready stream handshake with a global advance/stall.
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = N / STAGES;

  logic [N-1:0]      aQ     [STAGES];
  logic [N-1:0]      bxQ    [STAGES];
  logic [N-1:0]      resQ   [STAGES];
  logic [STAGES-1:0] carryQ;
  logic [STAGES-1:0] validQ;
  logic              ovfQ;
  logic              zeroQ;

  logic [N-1:0]      aD     [STAGES];
  logic [N-1:0]      bxD    [STAGES];
  logic [N-1:0]      resD   [STAGES];
  logic [STAGES-1:0] carryD;
  logic [STAGES-1:0] validD;
  logic              ovfD;
  logic              zeroD;

  logic [N-1:0]      aIn;
  logic [N-1:0]      bxIn;
  logic [N-1:0]      resIn;
  logic              cIn;
  logic              vIn;
  logic [W:0]        chunkSum;
  logic              adv;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign adv      = !validQ[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Stage k takes the previous register (or the ports for k=0) and resolves chunk k.
  always_comb begin
    aIn      = a;
    bxIn     = sub ? ~b : b;
    resIn    = '0;
    cIn      = cin;
    vIn      = in_valid;
    chunkSum = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k > 0) begin
        aIn   = aQ[(k > 0) ? k - 1 : 0];
        bxIn  = bxQ[(k > 0) ? k - 1 : 0];
        resIn = resQ[(k > 0) ? k - 1 : 0];
        cIn   = carryQ[(k > 0) ? k - 1 : 0];
        vIn   = validQ[(k > 0) ? k - 1 : 0];
      end
      chunkSum = {1'b0, aIn[k*W +: W]} + {1'b0, bxIn[k*W +: W]} + {{W{1'b0}}, cIn};
      resD[k]            = resIn;
      resD[k][k*W +: W]  = chunkSum[W-1:0];
      carryD[k]          = chunkSum[W];
      aD[k]              = aIn;
      bxD[k]             = bxIn;
      validD[k]          = vIn;
    end
    // Carry into the MSB recovered from the sum bit itself: a ^ bx ^ sum.
    ovfD  = aD[STAGES-1][N-1] ^ bxD[STAGES-1][N-1] ^ resD[STAGES-1][N-1] ^ carryD[STAGES-1];
    zeroD = (resD[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        aQ[k]   <= '0;
        bxQ[k]  <= '0;
        resQ[k] <= '0;
      end
      carryQ <= '0;
      validQ <= '0;
      ovfQ   <= 1'b0;
      zeroQ  <= 1'b0;
    end else if (adv) begin
      validQ <= validD;
      for (int k = 0; k < STAGES; k++) begin
        if (validD[k]) begin
          aQ[k]     <= aD[k];
          bxQ[k]    <= bxD[k];
          resQ[k]   <= resD[k];
          carryQ[k] <= carryD[k];
        end
      end
      if (validD[STAGES-1]) begin
        ovfQ  <= ovfD;
        zeroQ <= zeroD;
      end
    end
  end

  assign out_valid = validQ[STAGES-1];
  assign s         = resQ[STAGES-1];
  assign cout      = carryQ[STAGES-1];
  assign ovf       = ovfQ;
  assign zero      = zeroQ;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: three configurations, directed vectors,
// a randomized stalled stream against an arithmetic reference model, and mid-flight reset.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        opCin;
  logic        opSub;

  logic        rdy4, ov4, co4, of4, z4;
  logic [31:0] s4;
  logic        rdy1, ov1, co1, of1, z1;
  logic [31:0] s1;
  logic        rdy2, ov2, co2, of2, z2;
  logic [15:0] s2;

  pipelined_adder #(.N(32), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy4),
    .a(opA), .b(opB), .cin(opCin), .sub(opSub),
    .out_valid(ov4), .out_ready(outReady), .s(s4), .cout(co4), .ovf(of4), .zero(z4)
  );

  pipelined_adder #(.N(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy1),
    .a(opA), .b(opB), .cin(opCin), .sub(opSub),
    .out_valid(ov1), .out_ready(outReady), .s(s1), .cout(co1), .ovf(of1), .zero(z1)
  );

  pipelined_adder #(.N(16), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(rdy2),
    .a(opA[15:0]), .b(opB[15:0]), .cin(opCin), .sub(opSub),
    .out_valid(ov2), .out_ready(outReady), .s(s2), .cout(co2), .ovf(of2), .zero(z2)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference: plain integer arithmetic on an n-bit word; ovf means the signed sum left range.
  function automatic logic [34:0] refModel(input int n, input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic sb);
    longint mask, am, bm, total, lim, sA, sB, sSum;
    logic [31:0] sres;
    logic co, ov;
    mask  = (longint'(1) << n) - 1;
    am    = longint'(x) & mask;
    bm    = longint'(sb ? ~y : y) & mask;
    total = am + bm + longint'(c);
    sres  = 32'(total & mask);
    co    = ((total >> n) & 1) != 0;
    lim   = longint'(1) << (n - 1);
    sA    = (am >= lim) ? am - 2 * lim : am;
    sB    = (bm >= lim) ? bm - 2 * lim : bm;
    sSum  = sA + sB + longint'(c);
    ov    = (sSum >= lim) || (sSum < -lim);
    return {co, ov, (sres == 32'd0), sres};
  endfunction

  function automatic logic [34:0] pack4();
    return {co4, of4, z4, s4};
  endfunction
  function automatic logic [34:0] pack1();
    return {co1, of1, z1, s1};
  endfunction
  function automatic logic [34:0] pack2();
    return {co2, of2, z2, 16'h0000, s2};
  endfunction

  // One op into all three pipelines; latency and result of each are checked.
  task automatic applyStimulus(input string name, input logic [31:0] x, input logic [31:0] y,
                               input logic c, input logic sb);
    int          lat  [3];
    logic [34:0] got  [3];
    bit          seen [3];
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; got[i] = '0; seen[i] = 1'b0;
    end
    opA = x; opB = y; opCin = c; opSub = sb;
    inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("%s in_ready", name), {rdy4, rdy1, rdy2}, 3'b111);
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ov4 && !seen[0]) begin seen[0] = 1'b1; lat[0] = n; got[0] = pack4(); end
      if (ov1 && !seen[1]) begin seen[1] = 1'b1; lat[1] = n; got[1] = pack1(); end
      if (ov2 && !seen[2]) begin seen[2] = 1'b1; lat[2] = n; got[2] = pack2(); end
    end
    @(posedge clk); #1;
    checkOutput($sformatf("%s latency S4", name), lat[0], 4);
    checkOutput($sformatf("%s latency S1", name), lat[1], 1);
    checkOutput($sformatf("%s latency N16S2", name), lat[2], 2);
    checkOutput($sformatf("%s result S4", name), got[0], refModel(32, x, y, c, sb));
    checkOutput($sformatf("%s result S1", name), got[1], refModel(32, x, y, c, sb));
    checkOutput($sformatf("%s result N16S2", name), got[2], refModel(16, x, y, c, sb));
  endtask

  task automatic streamTest();
    logic [34:0] expQ [$];
    logic [34:0] held;
    bit          prevStall;
    int          issued, received;
    issued = 0; received = 0; prevStall = 1'b0; held = '0;
    opA = $urandom; opB = $urandom; opCin = 1'($urandom_range(0, 1)); opSub = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 60 && received < 8; cyc++) begin
      bit accepted;
      inValid  = (issued < 8) && (cyc != 10);
      outReady = !(cyc >= 6 && cyc <= 8);
      @(negedge clk);
      if (prevStall) checkOutput($sformatf("stall hold cyc %0d", cyc), pack4(), held);
      checkOutput($sformatf("in_ready rule cyc %0d", cyc), rdy4, !(ov4 && !outReady));
      prevStall = ov4 && !outReady;
      held      = pack4();
      if (ov4 && outReady) begin
        if (expQ.size() == 0) checkOutput("unexpected result", 1, 0);
        else begin
          checkOutput($sformatf("stream result %0d", received), pack4(), expQ.pop_front());
          received++;
        end
      end
      accepted = inValid && rdy4;
      if (accepted) begin
        expQ.push_back(refModel(32, opA, opB, opCin, opSub));
        issued++;
      end
      @(posedge clk); #1;
      if (accepted) begin
        opA = $urandom; opB = $urandom;
        opCin = 1'($urandom_range(0, 1)); opSub = 1'($urandom_range(0, 1));
      end
    end
    inValid = 1'b0; outReady = 1'b1;
    checkOutput("stream count", received, 8);
  endtask

  task automatic resetTest();
    int stale;
    stale = 0;
    outReady = 1'b1; opCin = 1'b0; opSub = 1'b0; opB = 32'd0;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      opA = $urandom | 32'd1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    checkOutput("pre-reset out_valid", ov4, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", {ov4, ov1, ov2}, 3'b000);
    checkOutput("async reset outputs S4", pack4(), '0);
    checkOutput("async reset outputs N16S2", pack2(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("in_ready after reset", rdy4, 1'b1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ov4 || ov1 || ov2) stale++;
    end
    @(posedge clk); #1;
    checkOutput("no stale result", stale, 0);
    applyStimulus("post-reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    opA = '0; opB = '0; opCin = 1'b0; opSub = 1'b0;
    #1;
    checkOutput("reset out_valid", {ov4, ov1, ov2}, 3'b000);
    checkOutput("reset outputs", pack4(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("ripple no cin", 32'h1111_1111, 32'hEEEE_EEEE, 1'b0, 1'b0);
    applyStimulus("ripple cin",    32'h1111_1111, 32'hEEEE_EEEE, 1'b1, 1'b0);
    applyStimulus("sub 5-7",       32'd5,         32'd7,         1'b1, 1'b1);
    applyStimulus("sub ovf",       32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    applyStimulus("add ovf",       32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0);

    streamTest();
    resetTest();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
